// File: rtl/nms_sequencer.sv
// -----------------------------------------------------------------------------
// nms_sequencer
//
// Frame-level sequencer for the edge-detector window datapath. It steps the
// processing anchor across the image in WINDOW_W-wide steps, row by row. For
// each step it waits for the line memory to present the window, then pulses
// anchor_moving for one cycle. It collects every stage's completion pulse
// before moving the anchor on. A watchdog bounds the time spent waiting for
// the stages.
//
// Ports
//   clk            rising-edge clock
//   n_rst          asynchronous active-low reset
//   start          single-cycle request to process one frame (accepted in IDLE)
//   abort          cancel the current frame; overrides every other transition
//   mem_ready      line memory holds the window at (anchor_x, anchor_y)
//   stage_final    per-stage completion pulses (bit 0 blur, 1 gradient, 2 NMS)
//   anchor_moving  one-cycle pulse: stages load a new window
//   anchor_x/y     coordinates of the current window
//   busy           a frame is in progress
//   frame_done     one-cycle pulse after the last window completes
//   timeout_err    sticky stage-timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module nms_sequencer #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int WINDOW_W     = 12,
  parameter int NUM_STAGES   = 3,
  parameter int TIMEOUT      = 255,
  // A one-row or one-column image still needs a 1-bit coordinate port.
  localparam int XW  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1,
  localparam int YW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int WDW = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mem_ready,
  input  logic [NUM_STAGES-1:0] stage_final,
  output logic                  anchor_moving,
  output logic [XW-1:0]         anchor_x,
  output logic [YW-1:0]         anchor_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MOVE,
    S_PROCESS,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NUM_STAGES-1:0]   done_mask;
  logic [WDW-1:0]          wdog;

  logic [NUM_STAGES-1:0]   mask_merged;
  logic                    all_done;
  logic [XW:0]             x_next_ext;
  logic                    row_end;
  logic                    last_row;
  logic                    wdog_expired;

  // A final arriving in the completing cycle counts toward completion.
  assign mask_merged  = done_mask | stage_final;
  assign all_done     = &mask_merged;

  // One bit wider than anchor_x so the row-end test cannot wrap; a partial
  // last window is still issued because the test happens after the step.
  assign x_next_ext   = {1'b0, anchor_x} + (XW+1)'(WINDOW_W);
  assign row_end      = (x_next_ext >= (XW+1)'(IMAGE_WIDTH));
  assign last_row     = (anchor_y == YW'(IMAGE_HEIGHT - 1));

  // True in the PROCESS cycle whose increment brings the count to TIMEOUT,
  // so at most TIMEOUT cycles are spent waiting for the stages.
  assign wdog_expired = (({1'b0, wdog} + (WDW+1)'(1)) >= (WDW+1)'(TIMEOUT));

  always_comb begin
    // NOTE: state_next is assigned a default before any branch, so every path
    // through this block drives it and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_FETCH;
      S_FETCH:   if (mem_ready) state_next = S_MOVE;
      S_MOVE:    state_next = S_PROCESS;
      S_PROCESS: begin
        if (all_done)          state_next = S_ADVANCE;
        else if (wdog_expired) state_next = S_IDLE;
      end
      S_ADVANCE: state_next = (row_end && last_row) ? S_DONE : S_FETCH;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    // abort wins over completion, timeout and start alike.
    if (abort) state_next = S_IDLE;
  end

  // Outputs are registered from state_next, so each one lines up with the
  // state it describes and none has a combinational path from an input.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      done_mask     <= '0;
      wdog          <= '0;
      anchor_x      <= '0;
      anchor_y      <= '0;
      anchor_moving <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // NOTE: every register here uses non-blocking assignment so all updates
      // see the pre-edge values and simulation matches the synthesized flops.
      state         <= state_next;
      anchor_moving <= (state_next == S_MOVE);
      busy          <= (state_next != S_IDLE);
      frame_done    <= (state_next == S_DONE);

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            anchor_x    <= '0;
            anchor_y    <= '0;
            done_mask   <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_MOVE: begin
          // Finals seen in the MOVE cycle belong to no window and are dropped.
          done_mask <= '0;
          wdog      <= '0;
        end
        S_PROCESS: begin
          done_mask <= mask_merged;
          wdog      <= wdog + WDW'(1);
          if (!all_done && wdog_expired && !abort) timeout_err <= 1'b1;
        end
        S_ADVANCE: begin
          if (!abort) begin
            if (row_end) begin
              anchor_x <= '0;
              if (!last_row) anchor_y <= anchor_y + YW'(1);
            end else begin
              anchor_x <= x_next_ext[XW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nms_sequencer
//
// Two sequencer instances share one clock and reset:
//   dut_a : 24 x 2 image, TIMEOUT 8   (basic frame, starvation, timeout, races)
//   dut_b : 30 x 1 image, TIMEOUT 255 (partial last window, staggered finals)
// Only one instance runs at a time (selected by act). Expected window
// coordinates are queued when a frame is started and popped by the monitor on
// every anchor_moving pulse. A responder drives each stage's final a
// configurable number of cycles after the most recent pulse.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_nms_sequencer;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  logic       n_rst;
  logic       start     [2];
  logic       abort     [2];
  logic       mem_ready [2];
  logic [2:0] fin       [2] = '{3'b000, 3'b000};
  logic       moving    [2];
  logic [4:0] ax        [2];
  logic [0:0] ay        [2];
  logic       busy      [2];
  logic       done      [2];
  logic       terr      [2];

  nms_sequencer #(
    .IMAGE_WIDTH(24), .IMAGE_HEIGHT(2), .WINDOW_W(12), .NUM_STAGES(3), .TIMEOUT(8)
  ) dut_a (
    .clk(tb_clk), .n_rst(n_rst), .start(start[0]), .abort(abort[0]),
    .mem_ready(mem_ready[0]), .stage_final(fin[0]), .anchor_moving(moving[0]),
    .anchor_x(ax[0]), .anchor_y(ay[0]), .busy(busy[0]), .frame_done(done[0]),
    .timeout_err(terr[0])
  );

  nms_sequencer #(
    .IMAGE_WIDTH(30), .IMAGE_HEIGHT(1), .WINDOW_W(12), .NUM_STAGES(3), .TIMEOUT(255)
  ) dut_b (
    .clk(tb_clk), .n_rst(n_rst), .start(start[1]), .abort(abort[1]),
    .mem_ready(mem_ready[1]), .stage_final(fin[1]), .anchor_moving(moving[1]),
    .anchor_x(ax[1]), .anchor_y(ay[1]), .busy(busy[1]), .frame_done(done[1]),
    .timeout_err(terr[1])
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act_v, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int inst;
    int x;
    int y;
  } coord_t;

  coord_t exp_q[$];
  coord_t mon_e;

  task automatic expect_win(input int inst, input int x, input int y);
    coord_t c;
    c.inst = inst;
    c.x    = x;
    c.y    = y;
    exp_q.push_back(c);
  endtask

  // ---------------------------------------------------------------- responder
  int         act       = 0;
  int         d[3]      = '{3, 3, 3};
  logic [2:0] en        = 3'b111;
  int         dup0      = -1;
  int         last_p[2] = '{-1000, -1000};
  int         npulse[2] = '{0, 0};
  int         ndone[2]  = '{0, 0};
  int         done_cyc[2] = '{0, 0};
  int         pcyc[$];
  int         xh[int];
  int         th[int];

  always @(negedge tb_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (moving[i] === 1'b1) begin
        last_p[i] = cyc;
        npulse[i]++;
        if (i == act) pcyc.push_back(cyc);
        check("pulse_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("pulse_inst", i, mon_e.inst);
          check("pulse_x", int'(ax[i]), mon_e.x);
          check("pulse_y", int'(ay[i]), mon_e.y);
        end
      end
      if (done[i] === 1'b1) begin
        ndone[i]++;
        done_cyc[i] = cyc;
      end
      for (int s = 0; s < 3; s++)
        fin[i][s] = (i == act) && en[s] &&
                    ((cyc - last_p[i] == d[s]) || (s == 0 && cyc - last_p[i] == dup0));
    end
    xh[cyc] = int'(ax[act]);
    th[cyc] = int'(terr[act]);
  end

  // ---------------------------------------------------------------- helpers
  // All stimulus and direct reads happen 1 ns after the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge tb_clk);
      #1;
    end
  endtask

  task automatic set_resp(input int d0, input int d1, input int d2,
                          input logic [2:0] en_v, input int dup);
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    en   = en_v;
    dup0 = dup;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    step(1);
    start[i] = 1'b0;
  endtask

  task automatic wait_pulse(input int i, input int budget, input string tag);
    int n0 = npulse[i];
    int t  = 0;
    while (npulse[i] == n0 && t < budget) begin
      step(1);
      t++;
    end
    check({tag, "_pulse_seen"}, int'(npulse[i] != n0), 1);
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int n0 = ndone[i];
    int t  = 0;
    while (ndone[i] == n0 && t < budget) begin
      step(1);
      t++;
    end
    check({tag, "_done_seen"}, int'(ndone[i] != n0), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int s_cyc, p_cyc, p0, dn0, r_cyc;

    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      abort[i]     = 1'b0;
      mem_ready[i] = 1'b1;
    end
    step(3);

    // Reset state
    check("rst_busy_a",   int'(busy[0]),   0);
    check("rst_moving_a", int'(moving[0]), 0);
    check("rst_done_a",   int'(done[0]),   0);
    check("rst_terr_a",   int'(terr[0]),   0);
    check("rst_x_a",      int'(ax[0]),     0);
    check("rst_y_a",      int'(ay[0]),     0);
    check("rst_busy_b",   int'(busy[1]),   0);
    n_rst = 1'b1;
    step(2);

    // Basic 4-window frame, finals 3 cycles after each pulse, stray start mid-frame
    act = 0;
    set_resp(3, 3, 3, 3'b111, -1);
    pcyc.delete();
    expect_win(0, 0, 0);
    expect_win(0, 12, 0);
    expect_win(0, 0, 1);
    expect_win(0, 12, 1);
    p0 = npulse[0];
    dn0 = ndone[0];
    s_cyc = cyc;
    check("t1_busy_before", int'(busy[0]), 0);
    pulse_start(0);
    check("t1_busy_next", int'(busy[0]), 1);
    wait_pulse(0, 20, "t1");
    check("t1_first_pulse_lat", pcyc[0] - s_cyc, 2);
    step(2);
    pulse_start(0);  // in PROCESS: must be ignored
    wait_done(0, 200, "t1");
    check("t1_pulses", npulse[0] - p0, 4);
    check("t1_period", pcyc[1] - pcyc[0], 6);
    check("t1_done_lat", done_cyc[0] - pcyc[3], 5);
    step(1);
    check("t1_busy_end", int'(busy[0]), 0);
    step(3);
    check("t1_done_once", ndone[0] - dn0, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Partial last window on the 30-wide image, best-case issue period
    act = 1;
    set_resp(1, 1, 1, 3'b111, -1);
    pcyc.delete();
    expect_win(1, 0, 0);
    expect_win(1, 12, 0);
    expect_win(1, 24, 0);
    p0 = npulse[1];
    pulse_start(1);
    wait_done(1, 200, "t2");
    check("t2_pulses", npulse[1] - p0, 3);
    check("t2_period", pcyc[1] - pcyc[0], 4);
    check("t2_a_quiet", npulse[0], 4);
    step(2);
    check("t2_queue_empty", exp_q.size(), 0);

    // Staggered finals 2/5/9 with a duplicate stage-0 final at 7
    set_resp(2, 5, 9, 3'b111, 7);
    pcyc.delete();
    expect_win(1, 0, 0);
    expect_win(1, 12, 0);
    expect_win(1, 24, 0);
    p0 = npulse[1];
    pulse_start(1);
    wait_done(1, 300, "t3");
    check("t3_pulses", npulse[1] - p0, 3);
    check("t3_period", pcyc[1] - pcyc[0], 12);
    check("t3_x_held_in_advance", xh[pcyc[0] + 10], 0);
    check("t3_x_after_advance", xh[pcyc[0] + 11], 12);
    check("t3_done_lat", done_cyc[1] - pcyc[2], 11);
    step(2);
    check("t3_queue_empty", exp_q.size(), 0);

    // Starved memory before the second window
    act = 0;
    set_resp(3, 3, 3, 3'b111, -1);
    pcyc.delete();
    expect_win(0, 0, 0);
    expect_win(0, 12, 0);
    expect_win(0, 0, 1);
    expect_win(0, 12, 1);
    p0 = npulse[0];
    pulse_start(0);
    wait_pulse(0, 20, "t4");
    mem_ready[0] = 1'b0;
    step(6);
    for (int k = 0; k < 20; k++) begin
      check("t4_no_pulse", int'(moving[0]), 0);
      check("t4_busy", int'(busy[0]), 1);
      check("t4_x_held", int'(ax[0]), 12);
      check("t4_y_held", int'(ay[0]), 0);
      step(1);
    end
    check("t4_pulse_count_starved", npulse[0] - p0, 1);
    mem_ready[0] = 1'b1;
    step(1);
    check("t4_pulse_after_ready", int'(moving[0]), 1);
    wait_done(0, 200, "t4");
    check("t4_pulses", npulse[0] - p0, 4);
    step(2);

    // Watchdog: stage 2 never finishes
    set_resp(3, 3, 3, 3'b011, -1);
    pcyc.delete();
    expect_win(0, 0, 0);
    p0 = npulse[0];
    dn0 = ndone[0];
    pulse_start(0);
    wait_pulse(0, 20, "t5");
    p_cyc = pcyc[0];
    step(12);
    check("t5_terr_not_early", th[p_cyc + 8], 0);
    check("t5_terr_set", th[p_cyc + 10], 1);
    check("t5_terr_sticky", int'(terr[0]), 1);
    check("t5_busy_idle", int'(busy[0]), 0);
    check("t5_no_done", ndone[0] - dn0, 0);
    check("t5_one_pulse", npulse[0] - p0, 1);

    // Next start clears the error and restarts at (0,0)
    set_resp(1, 1, 1, 3'b111, -1);
    expect_win(0, 0, 0);
    expect_win(0, 12, 0);
    expect_win(0, 0, 1);
    expect_win(0, 12, 1);
    p0 = npulse[0];
    pulse_start(0);
    check("t5_terr_cleared", int'(terr[0]), 0);
    wait_done(0, 200, "t5r");
    check("t5r_pulses", npulse[0] - p0, 4);
    step(2);

    // Abort in the same cycle as the completing final
    set_resp(3, 3, 3, 3'b111, -1);
    pcyc.delete();
    expect_win(0, 0, 0);
    p0 = npulse[0];
    dn0 = ndone[0];
    pulse_start(0);
    wait_pulse(0, 20, "t6");
    step(3);
    abort[0] = 1'b1;
    step(1);
    abort[0] = 1'b0;
    check("t6_busy_after_abort", int'(busy[0]), 0);
    check("t6_x_no_advance", int'(ax[0]), 0);
    step(10);
    check("t6_no_more_pulses", npulse[0] - p0, 1);
    check("t6_no_done", ndone[0] - dn0, 0);
    check("t6_no_terr", int'(terr[0]), 0);

    // Asynchronous reset mid-PROCESS on the second window
    expect_win(0, 0, 0);
    expect_win(0, 12, 0);
    p0 = npulse[0];
    dn0 = ndone[0];
    pulse_start(0);
    wait_pulse(0, 20, "t7a");
    wait_pulse(0, 20, "t7b");
    step(1);
    #2;
    n_rst = 1'b0;
    #1;
    check("t7_x_reset", int'(ax[0]), 0);
    check("t7_y_reset", int'(ay[0]), 0);
    check("t7_busy_reset", int'(busy[0]), 0);
    check("t7_moving_reset", int'(moving[0]), 0);
    check("t7_done_reset", int'(done[0]), 0);
    check("t7_terr_reset", int'(terr[0]), 0);
    step(1);
    n_rst = 1'b1;
    step(10);
    check("t7_no_more_pulses", npulse[0] - p0, 2);
    check("t7_no_done", ndone[0] - dn0, 0);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
